// File: rtl/uart_tx_pkg.sv
// Shared UART transmit definitions: FSM state encoding, parity-type constants
// and the default serializer timeout.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int SER_TIMEOUT_DEF = 16;

endpackage

// File: rtl/uart_parity_calc.sv
// Combinational parity bit for one byte; even parity is the XOR of the data,
// odd parity is its inverse.
module uart_parity_calc
    import uart_tx_pkg::*;
(
    input  logic [7:0] data_i,
    input  logic       par_typ_i,
    output logic       parity_o
);

    assign parity_o = (^data_i) ^ (par_typ_i == PAR_ODD);

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit frame controller: sequences start, serializer data, optional
// parity and stop bits onto the line, with serializer-timeout abort.
module uart_tx_frame_ctrl
    import uart_tx_pkg::*;
#(
    parameter int STOP_BITS   = 1,
    parameter int SER_TIMEOUT = SER_TIMEOUT_DEF
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] p_data_i,
    input  logic       data_valid_i,
    input  logic       par_en_i,
    input  logic       par_typ_i,
    input  logic       ser_done_i,
    input  logic       ser_data_i,
    output logic       ser_load_o,
    output logic [7:0] ser_p_data_o,
    output logic       ser_en_o,
    output logic       tx_out_o,
    output logic       busy_o,
    output logic       frame_err_o
);

    localparam logic [4:0] TO_LAST   = 5'(SER_TIMEOUT - 1);
    localparam logic [1:0] STOP_LAST = 2'(STOP_BITS - 1);

    tx_state_e  state_q, state_d;
    logic [7:0] data_q, data_d;
    logic       par_en_q, par_en_d;
    logic       par_typ_q, par_typ_d;
    logic [4:0] dcnt_q, dcnt_d;
    logic [1:0] scnt_q, scnt_d;
    logic       load_q, load_d;
    logic       ferr_q, ferr_d;
    logic       accept;
    logic       parity;

    uart_parity_calc u_par (
        .data_i    (data_q),
        .par_typ_i (par_typ_q),
        .parity_o  (parity)
    );

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        dcnt_d    = dcnt_q;
        scnt_d    = scnt_q;
        load_d    = 1'b0;
        ferr_d    = 1'b0;
        accept    = 1'b0;
        case (state_q)
            ST_IDLE: accept = data_valid_i;
            ST_START: begin
                state_d = ST_DATA;
                dcnt_d  = '0;
            end
            ST_DATA: begin
                if (ser_done_i) begin
                    state_d = par_en_q ? ST_PARITY : ST_STOP;
                    scnt_d  = '0;
                end else if (dcnt_q == TO_LAST) begin
                    state_d = ST_IDLE;
                    ferr_d  = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + 5'd1;
                end
            end
            ST_PARITY: begin
                state_d = ST_STOP;
                scnt_d  = '0;
            end
            ST_STOP: begin
                if (scnt_q == STOP_LAST) begin
                    accept  = data_valid_i;
                    state_d = ST_IDLE;
                end else begin
                    scnt_d = scnt_q + 2'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // New request only lands in IDLE or the last stop cycle.
        if (accept) begin
            state_d   = ST_START;
            data_d    = p_data_i;
            par_en_d  = par_en_i;
            par_typ_d = par_typ_i;
            load_d    = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            dcnt_q    <= '0;
            scnt_q    <= '0;
            load_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            dcnt_q    <= dcnt_d;
            scnt_q    <= scnt_d;
            load_q    <= load_d;
            ferr_q    <= ferr_d;
        end
    end

    // Line and handshake outputs depend on the state register only.
    always_comb begin
        tx_out_o = 1'b1;
        busy_o   = 1'b1;
        ser_en_o = 1'b0;
        case (state_q)
            ST_IDLE:   busy_o = 1'b0;
            ST_START: begin
                tx_out_o = 1'b0;
                ser_en_o = 1'b1;
            end
            ST_DATA: begin
                tx_out_o = ser_data_i;
                ser_en_o = 1'b1;
            end
            ST_PARITY: tx_out_o = parity;
            ST_STOP:   tx_out_o = 1'b1;
            default:   busy_o = 1'b0;
        endcase
    end

    assign ser_load_o   = load_q;
    assign ser_p_data_o = data_q;
    assign frame_err_o  = ferr_q;

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Bench for uart_tx_frame_ctrl: frame-level reference model plus directed
// frames, back-to-back, ignored request, timeout and reset scenarios.
module tb_uart_tx_frame_ctrl;

    localparam int SB = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       dv = 1'b0, par_en = 1'b0, par_typ = 1'b0;
    logic [7:0] pd = 8'h00;
    logic       ser_done, ser_data, ser_load, ser_en, tx, busy, ferr;
    logic [7:0] ser_p;
    int         n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    uart_tx_frame_ctrl #(.STOP_BITS(SB), .SER_TIMEOUT(16)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .p_data_i     (pd),
        .data_valid_i (dv),
        .par_en_i     (par_en),
        .par_typ_i    (par_typ),
        .ser_done_i   (ser_done),
        .ser_data_i   (ser_data),
        .ser_load_o   (ser_load),
        .ser_p_data_o (ser_p),
        .ser_en_o     (ser_en),
        .tx_out_o     (tx),
        .busy_o       (busy),
        .frame_err_o  (ferr)
    );

    // Serializer: loads on ser_load, shifts LSB-first while enabled.
    logic [7:0] sh = 8'h00;
    logic [3:0] shc = 4'd0;
    logic       stall = 1'b0;
    always @(posedge clk) begin
        if (ser_load) begin
            sh  <= ser_p;
            shc <= 4'd0;
        end else if (ser_en) begin
            sh  <= sh >> 1;
            shc <= shc + 4'd1;
        end
    end
    assign ser_data = sh[0];
    assign ser_done = !stall && (shc == 4'd7);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected line bits of a whole frame, index 0 = start bit.
    function automatic void frame_bits(input logic [7:0] b, input logic pe, input logic pt,
                                       output logic [11:0] bits, output int len);
        bits    = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = b[i];
        len = 9;
        if (pe) begin
            bits[9] = ((($countones(b) % 2) == 1) ? 1'b1 : 1'b0) ^ pt;
            len     = 10;
        end
        len += SB;
    endfunction

    typedef struct packed { logic tx; logic en; } bit_t;
    bit_t       q[$];
    logic       model_on = 1'b0;
    logic       exp_load = 1'b0;
    logic [7:0] exp_pd = 8'h00;

    // Compare this cycle, then advance using the inputs the next edge samples.
    initial forever begin
        logic [11:0] fb;
        int          fl;
        bit_t        e;
        @(negedge clk);
        if (model_on) begin
            if (q.size() > 0) begin
                chk("m_tx", tx, q[0].tx);
                chk("m_ser_en", ser_en, q[0].en);
                chk("m_busy", busy, 1);
            end else begin
                chk("m_idle_tx", tx, 1);
                chk("m_idle_busy", busy, 0);
                chk("m_idle_ser_en", ser_en, 0);
            end
            chk("m_ser_load", ser_load, exp_load);
            if (exp_load) chk("m_ser_p_data", ser_p, exp_pd);
            chk("m_frame_err", ferr, 0);
        end
        exp_load = 1'b0;
        if (rst || !model_on) begin
            q.delete();
        end else if (q.size() <= 1 && dv) begin
            q.delete();
            frame_bits(pd, par_en, par_typ, fb, fl);
            for (int i = 0; i < fl; i++) begin
                e.tx = fb[i];
                e.en = (i < 9);
                q.push_back(e);
            end
            exp_load = 1'b1;
            exp_pd   = pd;
        end else if (q.size() > 0) begin
            void'(q.pop_front());
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic pe, input logic pt);
        pd = b; par_en = pe; par_typ = pt; dv = 1'b1;
        cyc();
        dv = 1'b0;
    endtask

    task automatic grab(input int n, output logic [15:0] bits, inout int bc, inout int lc, inout int ec);
        bits = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bits[i] = tx;
            bc += int'(busy);
            lc += int'(ser_load);
            ec += int'(ferr);
        end
    endtask

    initial begin
        logic [15:0] bits;
        logic [11:0] fb;
        int          fl, bc, lc, ec;

        // Model pinned against hand-derived frames.
        frame_bits(8'hA5, 1'b0, 1'b0, fb, fl);
        chk("pin_a5_bits", fb[9:0], 10'b1101001010);
        chk("pin_a5_len", fl, 10);
        frame_bits(8'h07, 1'b1, 1'b0, fb, fl);
        chk("pin_07_even", fb[9], 1);
        chk("pin_07_len", fl, 11);
        frame_bits(8'h07, 1'b1, 1'b1, fb, fl);
        chk("pin_07_odd", fb[9], 0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ser_en", ser_en, 0);
        chk("rst_ser_load", ser_load, 0);
        chk("rst_frame_err", ferr, 0);
        chk("rst_ser_p_data", ser_p, 0);
        cyc();
        rst = 1'b0; model_on = 1'b1;
        cyc();

        // 0xA5 without parity
        bc = 0; lc = 0; ec = 0;
        send(8'hA5, 1'b0, 1'b0);
        grab(11, bits, bc, lc, ec);
        chk("a5_line", bits[9:0], 10'b1101001010);
        chk("a5_idle", bits[10], 1);
        chk("a5_busy_cycles", bc, 10);
        chk("a5_loads", lc, 1);
        cyc();

        // 0x07 even then odd parity
        bc = 0; lc = 0; ec = 0;
        send(8'h07, 1'b1, 1'b0);
        grab(12, bits, bc, lc, ec);
        chk("p07_even_bit", bits[9], 1);
        chk("p07_busy_cycles", bc, 11);
        cyc();
        send(8'h07, 1'b1, 1'b1);
        grab(12, bits, bc, lc, ec);
        chk("p07_odd_bit", bits[9], 0);
        chk("p07_stop", bits[10], 1);
        cyc();

        // Back-to-back 0x55 then 0xAA, second request in the final stop cycle
        bc = 0; lc = 0; ec = 0;
        send(8'h55, 1'b0, 1'b0);
        grab(9, bits, bc, lc, ec);
        @(posedge clk); #1;
        pd = 8'hAA; dv = 1'b1;
        grab(1, bits, bc, lc, ec);
        @(posedge clk); #1;
        dv = 1'b0;
        grab(11, bits, bc, lc, ec);
        chk("b2b_aa_line", bits[9:0], 10'b1101010100);
        chk("b2b_busy_cycles", bc, 20);
        chk("b2b_loads", lc, 2);
        chk("b2b_end_idle", bits[10], 1);
        cyc();

        // 0xFF request during DATA of a 0x00 frame is ignored
        bc = 0; lc = 0; ec = 0;
        send(8'h00, 1'b0, 1'b0);
        grab(3, bits, bc, lc, ec);
        @(posedge clk); #1;
        pd = 8'hFF; par_en = 1'b1; dv = 1'b1;
        @(posedge clk); #1;
        dv = 1'b0;
        lc = 0; bc = 0;
        grab(7, bits, bc, lc, ec);
        chk("ign_data_bits", bits[4:0], 0);
        chk("ign_stop", bits[5], 1);
        chk("ign_busy_cycles", bc, 6);
        chk("ign_loads", lc, 0);
        chk("ign_ser_p_data", ser_p, 8'h00);
        cyc();

        // Serializer never finishes: timeout abort
        model_on = 1'b0; stall = 1'b1;
        cyc();
        bc = 0; lc = 0; ec = 0;
        send(8'h3C, 1'b0, 1'b0);
        grab(17, bits, bc, lc, ec);
        chk("to_no_early_err", ec, 0);
        chk("to_busy_cycles", bc, 17);
        @(negedge clk);
        chk("to_frame_err", ferr, 1);
        chk("to_tx", tx, 1);
        chk("to_busy", busy, 0);
        chk("to_ser_en", ser_en, 0);
        @(negedge clk);
        chk("to_err_pulse", ferr, 0);
        cyc();
        stall = 1'b0;
        cyc();

        // Reset during the parity cycle
        bc = 0; lc = 0; ec = 0;
        send(8'h07, 1'b1, 1'b1);
        grab(9, bits, bc, lc, ec);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rp_parity_tx", tx, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rp_tx", tx, 1);
        chk("rp_busy", busy, 0);
        chk("rp_frame_err", ferr, 0);
        chk("rp_ser_p_data", ser_p, 0);
        cyc();
        model_on = 1'b1;
        cyc();
        send(8'hC3, 1'b1, 1'b0);
        grab(12, bits, bc, lc, ec);
        chk("rp_c3_line", bits[10:0], 11'b10110000110);
        chk("rp_c3_idle", bits[11], 1);
        cyc();

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            dv      = (i < 2000) ? ($urandom_range(3) == 0) : ($urandom_range(7) != 0);
            pd      = 8'($urandom);
            par_en  = 1'($urandom);
            par_typ = 1'($urandom);
            rst     = ($urandom_range(299) == 0);
            cyc();
        end
        dv = 1'b0; rst = 1'b0;
        repeat (16) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame_ctrl.md
UART_TX_FRAME_CTRL -- requirements
Module: uart_tx_frame_ctrl

Interface
REQ-001 Parameter STOP_BITS, default 1, number of stop-bit cycles per frame (legal values 1 or 2).
REQ-002 Parameter SER_TIMEOUT, default 16, maximum DATA-state cycles to wait for ser_done.
REQ-003 CLK  in  1  sole clock; all state updates on rising edge.
REQ-004 RST  in  1  reset, synchronous, active-high.
REQ-005 P_DATA  in  8  byte to transmit; sampled only on acceptance.
REQ-006 Data_Valid  in  1  request to send P_DATA.
REQ-007 PAR_EN  in  1  1 = insert parity bit; sampled on acceptance.
REQ-008 PAR_TYP  in  1  0 = even, 1 = odd; sampled on acceptance.
REQ-009 ser_done  in  1  serializer has driven its last data bit.
REQ-010 ser_data  in  1  current serial data bit from the serializer.
REQ-011 ser_load  out  1  one-cycle pulse instructing the serializer to load ser_p_data.
REQ-012 ser_p_data  out  8  registered copy of the accepted byte.
REQ-013 ser_en  out  1  serializer shift enable.
REQ-014 TX_OUT  out  1  UART line output; idle high.
REQ-015 busy  out  1  frame in progress; requests are not accepted.
REQ-016 frame_err  out  1  one-cycle pulse on a serializer timeout abort.

Function
REQ-017 FSM states SHALL be IDLE, START, DATA, PARITY, and STOP, held in a registered state variable.
REQ-018 IDLE: TX_OUT=1, busy=0, ser_en=0; when Data_Valid=1, latch P_DATA/PAR_EN/PAR_TYP, pulse ser_load for one cycle, and go to START.
REQ-019 START: exactly 1 cycle; TX_OUT=0, busy=1, ser_en=1; go to DATA.
REQ-020 DATA: TX_OUT=ser_data, ser_en=1; leave in the cycle ser_done=1 is sampled, going to PARITY if the latched PAR_EN=1, else to STOP.
REQ-021 PARITY: exactly 1 cycle; TX_OUT = XOR of the latched byte for even parity, or its inverse for odd; ser_en=0.
REQ-022 STOP: STOP_BITS cycles; TX_OUT=1; a 2-bit counter tracks the stop cycles.
REQ-023 At the end of the final STOP cycle, go to IDLE, or to START directly if Data_Valid=1 in that cycle (back-to-back: latch, pulse ser_load, busy stays 1).
REQ-024 Data_Valid in any state other than IDLE or the final STOP cycle SHALL be ignored, with no effect on the frame in progress.
REQ-025 A 5-bit DATA-cycle counter SHALL clear on DATA entry; if it reaches SER_TIMEOUT without ser_done, pulse frame_err for 1 cycle, drive TX_OUT=1, and go to IDLE.
REQ-026 Parity SHALL be computed from the latched byte only; later changes to P_DATA/PAR_EN/PAR_TYP do not affect the current frame.
REQ-027 TX_OUT SHALL be decoded only from the state register, latched parity, and ser_data, with no path from Data_Valid or P_DATA.
REQ-028 Resulting line sequence: start bit, 8 data bits LSB-first, optional parity bit, then STOP_BITS stop bits.

Reset
REQ-029 While RST=1 at a clock edge: state=IDLE; TX_OUT=1; busy=0; ser_en=0; ser_load=0; frame_err=0; ser_p_data=0; all counters 0.
REQ-030 RST asserted mid-frame SHALL abort the frame in the same edge, with TX_OUT high from the next cycle and no frame_err.

Structure
REQ-031 State encoding localparams, parity-type constants (EVEN=0, ODD=1), and the default SER_TIMEOUT SHALL live in the shared uart_tx package.
REQ-032 A single sub-module, uart_parity_calc (8-bit data plus type in, 1-bit parity out, combinational), SHALL be instantiated; everything else stays flat.

Verification
REQ-033 P_DATA=0xA5, PAR_EN=0, STOP_BITS=1, serializer model -> TX_OUT 0,1,0,1,0,0,1,0,1,1 then idle high; busy high for 10 cycles.
REQ-034 P_DATA=0x07, PAR_EN=1, PAR_TYP=0 -> parity bit 1; repeat with PAR_TYP=1 -> parity bit 0.
REQ-035 Two bytes 0x55 then 0xAA, second Data_Valid in the final STOP cycle -> no idle gap, busy never drops, second ser_load pulses exactly once.
REQ-036 Data_Valid pulsed with 0xFF during DATA of frame 0x00 -> ignored; only the 0x00 frame is transmitted.
REQ-037 Serializer model never asserts ser_done -> frame_err pulses once after 16 DATA cycles, TX_OUT=1, state IDLE.
REQ-038 RST=1 asserted in the PARITY state -> next cycle TX_OUT=1, busy=0, frame_err=0; a new frame then transmits correctly.
